// File: rtl/data_writeback_cache_controller_pkg.sv
// Shared types and constants for the write-back data cache miss controller.
package cache_pkg;

    typedef enum logic [1:0] {
        READY,
        WRITEBACK,
        FETCH
    } cache_state_t;

    // Byte offset within a 32-bit word; the word index starts above it.
    localparam int WORD_OFFSET_LSB = 2;

endpackage

// File: rtl/data_writeback_cache_controller_block_word_counter.sv
// Word-within-block counter used to sequence eviction and refill beats.
module block_word_counter #(
    parameter int blocksize = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         en_i,
    output logic [$clog2(blocksize)-1:0] cnt_o,
    output logic                         last_o
);

    localparam int CW = $clog2(blocksize);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CW'(blocksize - 1));

    // Next count: clear wins, otherwise advance and wrap after the last word.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_writeback_cache_controller.sv
// Miss-handling controller for the write-back data cache: detects hits,
// stalls on misses, evicts a dirty victim, then refills the block.
module data_writeback_cache_controller
    import cache_pkg::*;
#(
    parameter int tagbits   = 14,
    parameter int blocksize = 4,
    parameter int setbits   = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemRE,
    input  logic                         MemWE,
    input  logic [31:0]                  A,
    input  logic [tagbits-1:0]           CTag,
    input  logic                         CValid,
    input  logic                         CDirty,
    input  logic                         BusReady,
    output logic                         Stall,
    output logic                         CWE,
    output logic                         CDirtyIn,
    output logic                         CWDSel,
    output logic [$clog2(blocksize)-1:0] WordSel,
    output logic                         HRequest,
    output logic                         HWrite,
    output logic [31:0]                  HAddr
);

    localparam int CW      = $clog2(blocksize);
    localparam int BLK_LSB = WORD_OFFSET_LSB + CW;

    cache_state_t  state_q;
    cache_state_t  state_d;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          cnt_en;
    logic          cnt_clear;
    logic          access;
    logic          is_store;
    logic          hit;
    logic          unused_byte_offset;

    assign access             = MemRE | MemWE;
    assign is_store           = MemWE;
    assign hit                = CValid & (CTag == A[31 -: tagbits]);
    assign unused_byte_offset = ^A[WORD_OFFSET_LSB-1:0];

    // Counter only runs during bus beats; parked at zero while READY.
    assign cnt_clear = (state_q == READY);

    block_word_counter #(
        .blocksize (blocksize)
    ) u_word_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    // Next-state: miss picks eviction or refill; each phase ends on the last acked word.
    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        case (state_q)
            READY: begin
                if (access && !hit) begin
                    state_d = (CValid && CDirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                cnt_en = BusReady;
                if (BusReady && cnt_last) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cnt_en = BusReady;
                if (BusReady && cnt_last) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    // State register, asynchronously returned to READY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decoded from state, word count and inputs; reset suppresses cache writes.
    always_comb begin
        Stall    = 1'b0;
        CWE      = 1'b0;
        CDirtyIn = 1'b0;
        CWDSel   = 1'b0;
        WordSel  = '0;
        HRequest = 1'b0;
        HWrite   = 1'b0;
        HAddr    = '0;
        case (state_q)
            READY: begin
                if (access) begin
                    if (!hit) begin
                        Stall = 1'b1;
                    end else if (is_store) begin
                        CWE      = ~reset;
                        CDirtyIn = 1'b1;
                        WordSel  = A[WORD_OFFSET_LSB +: CW];
                    end
                end
            end
            WRITEBACK: begin
                Stall    = 1'b1;
                HRequest = 1'b1;
                HWrite   = 1'b1;
                HAddr    = {CTag, A[BLK_LSB +: setbits], cnt, {WORD_OFFSET_LSB{1'b0}}};
            end
            FETCH: begin
                Stall    = 1'b1;
                HRequest = 1'b1;
                HAddr    = {A[31:BLK_LSB], cnt, {WORD_OFFSET_LSB{1'b0}}};
                CWE      = BusReady;
                CWDSel   = 1'b1;
                WordSel  = cnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_writeback_cache_controller.sv
// Self-checking bench: a behavioural cache array answers the controller,
// and a per-set reference model predicts bus beats, stalls and cache writes.
module tb_data_writeback_cache_controller;

    localparam int TB    = 14;
    localparam int SB    = 14;
    localparam int BS    = 4;
    localparam int NSETS = 1 << SB;

    logic        clk;
    logic        reset;
    logic        MemRE;
    logic        MemWE;
    logic [31:0] A;
    logic [TB-1:0] CTag;
    logic        CValid;
    logic        CDirty;
    logic        BusReady;
    logic        Stall;
    logic        CWE;
    logic        CDirtyIn;
    logic        CWDSel;
    logic [1:0]  WordSel;
    logic        HRequest;
    logic        HWrite;
    logic [31:0] HAddr;

    // Cache storage as seen by the controller (written only by its CWE).
    logic [TB-1:0] env_tag   [NSETS];
    logic          env_valid [NSETS];
    logic          env_dirty [NSETS];
    // Reference model of the same storage, updated per completed access.
    logic [TB-1:0] ref_tag   [NSETS];
    logic          ref_valid [NSETS];
    logic          ref_dirty [NSETS];

    int n_checks = 0;
    int n_errors = 0;

    logic          pend;
    logic [SB-1:0] pend_set;
    logic [TB-1:0] pend_tag;
    logic          pend_dirty;

    data_writeback_cache_controller #(
        .tagbits   (TB),
        .blocksize (BS),
        .setbits   (SB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRE    (MemRE),
        .MemWE    (MemWE),
        .A        (A),
        .CTag     (CTag),
        .CValid   (CValid),
        .CDirty   (CDirty),
        .BusReady (BusReady),
        .Stall    (Stall),
        .CWE      (CWE),
        .CDirtyIn (CDirtyIn),
        .CWDSel   (CWDSel),
        .WordSel  (WordSel),
        .HRequest (HRequest),
        .HWrite   (HWrite),
        .HAddr    (HAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign CTag   = env_tag[A[SB+3:4]];
    assign CValid = env_valid[A[SB+3:4]];
    assign CDirty = env_dirty[A[SB+3:4]];

    function automatic logic [31:0] mk(input logic [TB-1:0] t, input logic [SB-1:0] s,
                                       input logic [1:0] w);
        return {t, s, w, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Record the cache write requested this cycle; it lands after the next edge.
    task automatic capture();
        if (CWE === 1'b1) begin
            pend       = 1'b1;
            pend_set   = A[SB+3:4];
            pend_tag   = A[31:32-TB];
            pend_dirty = CDirtyIn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pend) begin
            env_tag[pend_set]   = pend_tag;
            env_valid[pend_set] = 1'b1;
            env_dirty[pend_set] = pend_dirty;
            pend = 1'b0;
        end
    endtask

    task automatic set_line(input logic [SB-1:0] s, input logic [TB-1:0] t,
                            input logic v, input logic d);
        env_tag[s] = t; env_valid[s] = v; env_dirty[s] = d;
        ref_tag[s] = t; ref_valid[s] = v; ref_dirty[s] = d;
    endtask

    task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                             input int wait_pct, output int stall_cycles);
        logic [SB-1:0] s;
        logic [TB-1:0] t;
        logic          store;
        logic          hit;
        int            nwb, beat, waits, fills;
        logic [31:0]   exp_addr[$];
        logic          exp_wr[$];
        s     = addr[SB+3:4];
        t     = addr[31:32-TB];
        store = we;
        hit   = ref_valid[s] && (ref_tag[s] == t);
        nwb   = (!hit && ref_valid[s] && ref_dirty[s]) ? BS : 0;
        if (!hit) begin
            for (int i = 0; i < nwb; i++) begin
                exp_addr.push_back({ref_tag[s], s, 4'h0} + 32'(i * 4));
                exp_wr.push_back(1'b1);
            end
            for (int i = 0; i < BS; i++) begin
                exp_addr.push_back({addr[31:4], 4'h0} + 32'(i * 4));
                exp_wr.push_back(1'b0);
            end
        end
        MemRE    = re;
        MemWE    = we;
        A        = addr;
        BusReady = ($urandom_range(0, 99) >= wait_pct);
        #1;
        stall_cycles = 0; beat = 0; waits = 0; fills = 0;
        for (int cyc = 0; cyc < 300 && Stall === 1'b1; cyc++) begin
            stall_cycles++;
            if (cyc == 0 || beat >= exp_addr.size()) begin
                check("miss_ready_hreq", HRequest, 0);
                check("miss_ready_cwe", CWE, 0);
            end else begin
                check("beat_hreq", HRequest, 1);
                check("beat_hwrite", HWrite, exp_wr[beat]);
                check("beat_haddr", HAddr, exp_addr[beat]);
                check("beat_cwe", CWE, !exp_wr[beat] && BusReady);
                if (!exp_wr[beat] && BusReady) begin
                    check("fill_wordsel", WordSel, beat - nwb);
                    check("fill_cwdsel", CWDSel, 1);
                    check("fill_dirtyin", CDirtyIn, 0);
                    fills++;
                end
                if (BusReady) beat++;
                else waits++;
            end
            capture();
            tick();
            BusReady = ($urandom_range(0, 99) >= wait_pct);
            #1;
        end
        check("stall_released", Stall, 0);
        check("beats_done", beat, exp_addr.size());
        check("fill_pulses", fills, hit ? 0 : BS);
        check("stall_cycles", stall_cycles, hit ? 0 : 1 + exp_addr.size() + waits);
        check("done_hreq", HRequest, 0);
        check("done_cwe", CWE, store);
        if (store) begin
            check("store_wordsel", WordSel, addr[3:2]);
            check("store_dirtyin", CDirtyIn, 1);
            check("store_cwdsel", CWDSel, 0);
        end
        capture();
        if (!hit) begin
            ref_tag[s] = t; ref_valid[s] = 1'b1; ref_dirty[s] = 1'b0;
        end
        if (store) ref_dirty[s] = 1'b1;
        tick();
        MemRE = 1'b0; MemWE = 1'b0; BusReady = 1'b0;
        #1;
        check("line_tag", env_tag[s], ref_tag[s]);
        check("line_valid", env_valid[s], ref_valid[s]);
        check("line_dirty", env_dirty[s], ref_dirty[s]);
        check("idle_stall", Stall, 0);
        check("idle_hreq", HRequest, 0);
        check("idle_cwe", CWE, 0);
    endtask

    initial begin
        int sc;
        int hreq_cycles;
        int wp[3];
        logic [TB-1:0] tags[4];
        wp   = '{0, 30, 60};
        reset = 1'b1; MemRE = 1'b0; MemWE = 1'b0; A = '0; BusReady = 1'b0; pend = 1'b0;
        for (int unsigned i = 0; i < NSETS; i++) begin
            set_line(SB'(i), '0, 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", Stall, 0);
        check("rst_hreq", HRequest, 0);
        check("rst_cwe", CWE, 0);
        // Store hit and miss presented while reset is held.
        set_line(5, 14'h12A, 1'b1, 1'b0);
        MemWE = 1'b1; A = mk(14'h12A, 5, 2);
        #1;
        check("rst_storehit_cwe", CWE, 0);
        check("rst_storehit_stall", Stall, 0);
        A = mk(14'h0BB, 5, 0);
        #1;
        check("rst_miss_stall", Stall, 1);
        check("rst_miss_hreq", HRequest, 0);
        check("rst_miss_hwrite", HWrite, 0);
        tick();
        reset = 1'b0; MemWE = 1'b0;
        #1;

        do_access(1'b1, 1'b0, mk(14'h12A, 5, 0), 0, sc);
        check("load_hit_stall", sc, 0);

        set_line(5, 14'h12A, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, mk(14'h12A, 5, 0), 0, sc);
        check("clean_miss_penalty", sc, 5);

        set_line(5, 14'h0AA, 1'b1, 1'b1);
        do_access(1'b0, 1'b1, mk(14'h12A, 5, 1), 0, sc);
        check("dirty_miss_penalty", sc, 9);

        set_line(6, 14'h0, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, mk(14'h12A, 6, 0), 50, sc);

        do_access(1'b0, 1'b1, mk(14'h12A, 5, 2), 0, sc);
        check("store_hit_stall", sc, 0);

        // Reset during eviction at word 2, then a fresh miss whose access drops mid-way.
        set_line(7, 14'h0AA, 1'b1, 1'b1);
        MemWE = 1'b1; A = mk(14'h12A, 7, 0); BusReady = 1'b1;
        #1;
        check("rwb_pre_stall", Stall, 1);
        tick(); tick(); tick();
        #1;
        check("rwb_haddr_cnt2", HAddr, mk(14'h0AA, 7, 2));
        check("rwb_hwrite", HWrite, 1);
        reset = 1'b1;
        #1;
        check("rwb_async_hreq", HRequest, 0);
        check("rwb_async_hwrite", HWrite, 0);
        check("rwb_async_cwe", CWE, 0);
        check("rwb_async_stall", Stall, 1);
        tick();
        #1;
        check("rwb_held_hreq", HRequest, 0);
        reset = 1'b0;
        #1;
        check("rwb_ready_stall", Stall, 1);
        check("rwb_ready_hreq", HRequest, 0);
        tick();
        #1;
        check("rwb_restart_hreq", HRequest, 1);
        check("rwb_restart_haddr", HAddr, mk(14'h0AA, 7, 0));
        MemWE = 1'b0;
        hreq_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            capture();
            tick();
            #1;
            if (HRequest !== 1'b1) break;
            hreq_cycles++;
        end
        check("rwb_no_abort_beats", hreq_cycles, 2 * BS);
        check("rwb_idle_stall", Stall, 0);
        ref_tag[7] = 14'h12A; ref_valid[7] = 1'b1; ref_dirty[7] = 1'b0;
        check("rwb_line_tag", env_tag[7], ref_tag[7]);
        check("rwb_line_dirty", env_dirty[7], ref_dirty[7]);

        // Randomized traffic over a few sets and a small tag pool.
        tags = '{14'h12A, 14'h0AA, 14'h3FFF, 14'h0001};
        for (int n = 0; n < 150; n++) begin
            int op;
            logic [TB-1:0] t;
            op = $urandom_range(0, 2);
            t  = tags[$urandom_range(0, 3)];
            do_access(op != 1, op != 0,
                      mk(t, SB'($urandom_range(0, 7)), 2'($urandom_range(0, 3))),
                      wp[$urandom_range(0, 2)], sc);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_writeback_cache_controller.md
Name: data_writeback_cache_controller

Overview:
Miss-handling controller for the write-back data cache memory. It runs beside the memory stage and drives the cache's write enable, dirty-in, word select and write-data select. It detects hits and misses and stalls the pipeline. On a miss it evicts a dirty victim block, then refills the block one word per bus acknowledge.

Parameters:
tagbits, 14, width of the stored tag (address bits [31:32-tagbits])
blocksize, 4, words per block; power of two
setbits, 14, set-index width; set = A[setbits+3:4] for blocksize 4

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
MemRE  input  1  load request from memory stage
MemWE  input  1  store request from memory stage
A  input  32  CPU byte address
CTag  input  tagbits  tag read from cache at set(A)
CValid  input  1  valid bit read from cache
CDirty  input  1  dirty bit read from cache
BusReady  input  1  bus accepted or returned one word this cycle
Stall  output  1  hold memory stage and everything upstream
CWE  output  1  cache write enable
CDirtyIn  output  1  dirty value written with CWE (drives cache MemWriteM)
CWDSel  output  1  0 = CPU write data, 1 = bus read data
WordSel  output  $clog2(blocksize)  word of block to write
HRequest  output  1  bus transaction active
HWrite  output  1  1 = bus write (eviction), 0 = bus read (fill)
HAddr  output  32  word address on bus

Behaviour:
- Hit = CValid & (CTag == A[31:32-tagbits]); Access = MemRE | MemWE. If MemRE and MemWE are both 1, the access is treated as a store.
- State register: READY, WRITEBACK, FETCH. Word counter Cnt is $clog2(blocksize) bits. Both are reset asynchronously to READY / 0.
- All outputs are combinational from state, Cnt and inputs. While reset is held: Stall = Access & ~Hit; CWE, HRequest and HWrite are 0.
- READY:
  - Access & Hit, load: Stall=0, no writes.
  - Access & Hit, store: CWE=1, CWDSel=0, CDirtyIn=1, WordSel=A[3:2], Stall=0. The write commits on that edge.
  - Access & ~Hit: Stall=1. Next state is WRITEBACK if CValid & CDirty, else FETCH.
  - No Access: idle, all outputs 0.
- WRITEBACK:
  - HRequest=1, HWrite=1, HAddr={CTag, A[setbits+3:4], Cnt, 2'b00}, Stall=1.
  - Cnt increments on BusReady. Cache data RD[Cnt] is the bus write data (datapath mux).
  - Cnt==blocksize-1 & BusReady: Cnt wraps to 0, next state FETCH.
- FETCH:
  - HRequest=1, HWrite=0, HAddr={A[31:4], Cnt, 2'b00}, Stall=1.
  - CWE=BusReady, CWDSel=1, CDirtyIn=0, WordSel=Cnt. Cnt increments on BusReady.
  - Cnt==blocksize-1 & BusReady: Cnt wraps to 0, next state READY.
  - The following READY cycle sees a hit and completes the load or store. Miss penalty is (evicted words + blocksize + 1) cycles at zero bus wait states.
- BusReady low in WRITEBACK or FETCH holds state and Cnt, and keeps HAddr stable.
- Access dropping during WRITEBACK or FETCH does not abort; the refill completes.
- Reset mid-operation returns immediately to READY with Cnt=0 and HRequest=0. The partial block stays in the cache with its existing valid and tag. The bus slave must tolerate the abandoned transfer.
- Tag and valid bits update on every fill word (the cache's behaviour). Hit is not evaluated outside READY.

Decomposition:
- Package cache_pkg: typedef enum logic [1:0] {READY, WRITEBACK, FETCH} cache_state_t; localparam WORD_OFFSET_LSB = 2.
- One sub-module: block_word_counter. Has clear, enable and last-word flag; parameterised by blocksize; asynchronous reset.

Test Plan:
- Load hit: preload set 5 valid, tag 0x12A; MemRE with A={0x12A,set5,0x0} -> Stall=0, CWE=0, no HRequest.
- Clean read miss: set 5 invalid, MemRE, BusReady=1 -> 4 FETCH cycles with HAddr=A&~0xF + 0,4,8,C and CWE=1 each; then READY with Stall=0; total stall 5 cycles.
- Dirty store miss: set 5 dirty, tag 0x0AA; MemWE to tag 0x12A -> 4 writes with HAddr={0x0AA,set5,Cnt,00}, then 4 fills, then a store with CDirtyIn=1; 9 stall cycles.
- Bus wait states: BusReady toggles 1,0,0,1,... in FETCH -> Cnt and HAddr hold while BusReady=0; exactly 4 CWE pulses.
- Reset mid-WRITEBACK at Cnt=2 -> next cycle HRequest=0, state READY, Cnt=0, Stall=Access&~Hit.
- Store hit: MemWE hit, A[3:2]=2 -> CWE=1, WordSel=2, CDirtyIn=1, Stall=0.
